h264_coretransform_pp: RTL and testbench
========================================

// Module: h264_coretransform_pp
// PURPOSE
//  Parametrised 4x4 forward transform for the H.264 residual path, successor to the fixed-width core transform.
//  Accepts one residual row per ENABLE beat, streams 16 coefficients out serially, one per cycle.
//  Runtime MODE selects the integer core transform (Cf) or the 4x4 luma-DC Hadamard.
//  Ping-pong block buffer lets loading of block n+1 overlap draining of block n.
// PARAMETERS
//  IN_W         9   signed residual sample width (two's complement)
//  HADAMARD_EN  1   1: MODE input honoured; 0: MODE ignored, core transform only
//  OUT_W        IN_W+6 (localparam, not overridable) coefficient width, full precision, no saturation
// PORTS
//  CLK     in   1         clock, rising edge
//  RESET   in   1         asynchronous, active-high reset
//  ENABLE  in   1         row beat valid; row accepted on edge where ENABLE && READY
//  XXIN    in   4*IN_W    one row; column j at XXIN[j*IN_W +: IN_W], signed
//  MODE    in   1         0 = core Cf, 1 = Hadamard; sampled with row 0 of each block
//  READY   out  1         registered; 1 = write bank can accept a row
//  VALID   out  1         registered; YNOUT holds a coefficient
//  YNOUT   out  OUT_W     signed coefficient, registered
// BEHAVIOUR
//  Reset (async): READY=1, VALID=0, YNOUT=0, both banks empty, row counter=0, write/read bank ptr=0.
//  Matrices: Cf={1,1,1,1;2,1,-1,-2;1,-1,-1,1;1,-2,2,-1}; H={1,1,1,1;1,1,-1,-1;1,-1,-1,1;1,-1,1,-1}.
//  Load: accepted row r (0..3) -> h[r][v]=sum_j M[v][j]*X[r][j], stored IN_W+3 bits in write bank.
//   ENABLE low holds row counter; gaps between rows allowed. MODE latched per bank at row 0.
//   Row 3 accepted -> bank marked full, write ptr toggles, row counter wraps to 0.
//  Drain: read engine runs whenever read bank full; each cycle registers Y[u][v]=sum_i M[u][i]*h[i][v],
//   order k=0..15, u=k/4, v=k%4 (row-major). Hadamard: result >>>1 (arithmetic, floor).
//  Latency: row 3 accepted at edge t -> Y[0][0] valid after edge t+1; VALID high 16 consecutive cycles.
//   Bank freed on edge that registers k=15; if other bank full, its k=0 follows next cycle (no bubble).
//  READY next = write bank not full after this edge's updates; deasserts after 8th row with no drain
//   progress; reasserts the cycle after the bank is freed. ENABLE while READY=0 is ignored.
//  Simultaneous: row 3 into bank A and k=15 out of bank B on one edge -> both take effect; drain of A
//   starts next cycle.
//  VALID=0 -> YNOUT holds last value (not cleared).
//  Reset mid-block or mid-drain: all partial data discarded, outputs to reset values asynchronously.
//  Widths: core max |Y|=36*2^(IN_W-1) fits OUT_W; Hadamard fits IN_W+4.
// STRUCTURE
//  Package h264_transform_pkg: mode_e {MODE_CORE, MODE_HAD}, Cf and H coefficient constants, width helpers.
//  Sub-module h264_transform_1d: combinational 4-point butterfly, mode select, generic width;
//   instantiated for row pass (4 outputs) and column pass (select output u).
//  Top: two banks of 4x4 x (IN_W+3), per-bank full flag and mode, row counter, coefficient counter k.
// TESTING
//  1 Core, all-zero block -> VALID 16 cycles from cycle after row 3, all YNOUT=0.
//  2 Core, all samples 1 -> Y00=16, other 15 coefficients 0; then all -256 -> Y00=-4096.
//  3 Core, every row {0,1,2,3} -> Y00..Y03 = 24,-28,0,-4; Y10..Y33 = 0.
//  4 MODE=1, all 255 -> Y00=2040, rest 0; all -256 -> Y00=-2048; HADAMARD_EN=0 same stimulus -> Y00=4080.
//  5 Continuous ENABLE, 3 blocks -> READY low after 8th row until block 1 k=15; 48 VALID cycles, no bubble.
//  6 RESET at k=5 of drain, ENABLE gaps on next block -> VALID=0/YNOUT=0/READY=1 immediately; next block correct.

Source files
------------

// File: rtl/h264_transform_pkg.sv
// Shared definitions for the H.264 4x4 forward transform.
//   mode_e       : transform selector (integer core transform or luma-DC Hadamard)
//   CF_M / HAD_M : coefficient matrices, row v gives the weights for output v
//   row_w()      : width after one 1-D pass (each pass grows the word by 3 bits)
//   coef_w()     : width after both passes (full precision, no saturation)
package h264_transform_pkg;

    typedef enum logic {
        MODE_CORE = 1'b0,
        MODE_HAD  = 1'b1
    } mode_e;

    localparam int BLK_N       = 4;
    localparam int PASS_GROWTH = 3;

    localparam int CF_M [BLK_N][BLK_N] = '{
        '{1,  1,  1,  1},
        '{2,  1, -1, -2},
        '{1, -1, -1,  1},
        '{1, -2,  2, -1}
    };

    localparam int HAD_M [BLK_N][BLK_N] = '{
        '{1,  1,  1,  1},
        '{1,  1, -1, -1},
        '{1, -1, -1,  1},
        '{1, -1,  1, -1}
    };

    function automatic int row_w(input int in_w);
        return in_w + PASS_GROWTH;
    endfunction

    function automatic int coef_w(input int in_w);
        return in_w + 2 * PASS_GROWTH;
    endfunction

endpackage

// File: rtl/h264_transform_1d.sv
// Combinational 4-point transform (butterfly form) for either matrix.
//   x    : four signed W-bit inputs, element i at x[i*W +: W]
//   mode : MODE_CORE applies Cf, MODE_HAD applies the Hadamard matrix
//   y    : four signed (W+3)-bit outputs, element v at y[v*(W+3) +: W+3]
// The output is 3 bits wider than the input, so no intermediate can overflow.
module h264_transform_1d
    import h264_transform_pkg::*;
#(
    parameter  int W  = 9,
    localparam int YW = row_w(W)
) (
    input  logic [4*W-1:0]  x,
    input  mode_e           mode,
    output logic [4*YW-1:0] y
);

    logic signed [YW-1:0] xe [4];
    logic signed [YW-1:0] s0, s1, d0, d1;
    logic signed [YW-1:0] y0, y1, y2, y3;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            xe[i] = YW'($signed(x[i*W +: W]));
        end
        // Shared butterfly: sums/differences of the outer and inner pairs.
        s0 = xe[0] + xe[3];
        s1 = xe[1] + xe[2];
        d0 = xe[0] - xe[3];
        d1 = xe[1] - xe[2];
        y0 = s0 + s1;
        y2 = s0 - s1;
        if (mode == MODE_HAD) begin
            y1 = d0 + d1;
            y3 = d0 - d1;
        end else begin
            y1 = (d0 <<< 1) + d1;
            y3 = d0 - (d1 <<< 1);
        end
    end

    assign y = {y3, y2, y1, y0};

endmodule

// File: rtl/h264_coretransform_pp.sv
// 4x4 forward transform with a ping-pong block buffer.
//   CLK, RESET : clock (rising edge), asynchronous active-high reset
//   ENABLE     : row beat valid; a row is taken on an edge where ENABLE && READY
//   XXIN       : one residual row, column j at XXIN[j*IN_W +: IN_W]
//   MODE       : 0 core transform, 1 Hadamard; sampled with row 0 of each block
//   READY      : registered, write bank can take a row
//   VALID      : registered, YNOUT holds a coefficient
//   YNOUT      : registered signed coefficient, row-major order k=0..15
// Handshake: input rows move on ENABLE && READY; the output side has no
// backpressure, VALID marks each of the 16 coefficients of a block.
// The row pass is applied on load and the partial results stored; the column
// pass runs during drain, one coefficient per cycle, from the read bank.
module h264_coretransform_pp
    import h264_transform_pkg::*;
#(
    parameter  int IN_W        = 9,
    parameter  bit HADAMARD_EN = 1'b1,
    localparam int OUT_W       = coef_w(IN_W)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic [4*IN_W-1:0] XXIN,
    input  logic              MODE,
    output logic              READY,
    output logic              VALID,
    output logic [OUT_W-1:0]  YNOUT
);

    localparam int HW = row_w(IN_W);

    logic [HW-1:0]    bank_q [2][4][4];
    mode_e            mode_q [2];
    logic [1:0]       full_q, full_n;
    logic             wr_ptr_q, wr_ptr_n, rd_ptr_q;
    logic [1:0]       row_q;
    logic [3:0]       k_q;
    logic             ready_q, ready_n, valid_q;
    logic [OUT_W-1:0] ynout_q;

    logic                    accept, drain, last_row, last_k;
    mode_e                   mode_in, row_mode, col_mode;
    logic [4*HW-1:0]         row_h;
    logic [4*HW-1:0]         col_x;
    logic [4*OUT_W-1:0]      col_y;
    logic signed [OUT_W-1:0] col_sel, coef;

    assign accept   = ENABLE && ready_q;
    assign last_row = (row_q == 2'd3);
    assign drain    = full_q[rd_ptr_q];
    assign last_k   = (k_q == 4'd15);
    assign mode_in  = (HADAMARD_EN && MODE) ? MODE_HAD : MODE_CORE;
    // Row 0 uses the live MODE; later rows use what was latched for the bank.
    assign row_mode = (row_q == 2'd0) ? mode_in : mode_q[wr_ptr_q];
    assign col_mode = mode_q[rd_ptr_q];

    h264_transform_1d #(.W(IN_W)) u_row (
        .x    (XXIN),
        .mode (row_mode),
        .y    (row_h)
    );

    // Column v = k%4 of the read bank feeds the column pass.
    always_comb begin
        col_x = '0;
        for (int i = 0; i < 4; i++) begin
            col_x[i*HW +: HW] = bank_q[rd_ptr_q][i][k_q[1:0]];
        end
    end

    h264_transform_1d #(.W(HW)) u_col (
        .x    (col_x),
        .mode (col_mode),
        .y    (col_y)
    );

    always_comb begin
        col_sel = col_y[int'(k_q[3:2])*OUT_W +: OUT_W];
        coef    = (col_mode == MODE_HAD) ? (col_sel >>> 1) : col_sel;
    end

    // Bank occupancy after this edge; fill and free never hit the same bank.
    always_comb begin
        full_n   = full_q;
        wr_ptr_n = wr_ptr_q;
        if (drain && last_k) begin
            full_n[rd_ptr_q] = 1'b0;
        end
        if (accept && last_row) begin
            full_n[wr_ptr_q] = 1'b1;
            wr_ptr_n         = ~wr_ptr_q;
        end
        ready_n = ~full_n[wr_ptr_n];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int b = 0; b < 2; b++) begin
                mode_q[b] <= MODE_CORE;
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        bank_q[b][r][c] <= '0;
                    end
                end
            end
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            row_q    <= '0;
            k_q      <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            ynout_q  <= '0;
        end else begin
            full_q   <= full_n;
            wr_ptr_q <= wr_ptr_n;
            ready_q  <= ready_n;
            if (accept) begin
                for (int v = 0; v < 4; v++) begin
                    bank_q[wr_ptr_q][row_q][v] <= row_h[v*HW +: HW];
                end
                if (row_q == 2'd0) begin
                    mode_q[wr_ptr_q] <= mode_in;
                end
                row_q <= row_q + 2'd1;
            end
            if (drain) begin
                ynout_q <= coef;
                valid_q <= 1'b1;
                k_q     <= k_q + 4'd1;
                if (last_k) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign READY = ready_q;
    assign VALID = valid_q;
    assign YNOUT = ynout_q;

endmodule

// File: tb/tb_h264_coretransform_pp.sv
module tb_h264_coretransform_pp;

    localparam int IN_W  = 9;
    localparam int OUT_W = IN_W + 6;

    typedef int blk_t [4][4];
    typedef int coef_t [16];
    typedef struct {
        blk_t  x;
        bit    mode;
        coef_t y;
        coef_t y_nh;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable, mode;
    logic [4*IN_W-1:0] xxin;
    logic              ready, valid, ready_nh, valid_nh;
    logic [OUT_W-1:0]  ynout, ynout_nh;

    always #5 clk = ~clk;

    h264_coretransform_pp #(.IN_W(IN_W), .HADAMARD_EN(1'b1)) dut (
        .CLK(clk), .RESET(rst), .ENABLE(enable), .XXIN(xxin), .MODE(mode),
        .READY(ready), .VALID(valid), .YNOUT(ynout)
    );

    h264_coretransform_pp #(.IN_W(IN_W), .HADAMARD_EN(1'b0)) dut_nh (
        .CLK(clk), .RESET(rst), .ENABLE(enable), .XXIN(xxin), .MODE(mode),
        .READY(ready_nh), .VALID(valid_nh), .YNOUT(ynout_nh)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] exp_nh_q[$];
    logic [OUT_W-1:0] mon_e;

    int CF [4][4] = '{'{1,1,1,1}, '{2,1,-1,-2}, '{1,-1,-1,1}, '{1,-2,2,-1}};
    int HM [4][4] = '{'{1,1,1,1}, '{1,1,-1,-1}, '{1,-1,-1,1}, '{1,-1,1,-1}};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: Y = M * X * M^T, Hadamard halved with floor.
    function automatic void model(input blk_t x, input bit had, output coef_t y);
        int m [4][4];
        int t;
        m = had ? HM : CF;
        for (int u = 0; u < 4; u++) begin
            for (int v = 0; v < 4; v++) begin
                t = 0;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        t += m[u][i] * x[i][j] * m[v][j];
                y[u*4+v] = had ? (t >>> 1) : t;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (valid) begin
            if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("ynout", int'($signed(ynout)), int'($signed(mon_e)));
            end
        end
        if (valid_nh) begin
            if (exp_nh_q.size() == 0) check("unexpected_valid_nh", 1, 0);
            else begin
                mon_e = exp_nh_q.pop_front();
                check("ynout_nh", int'($signed(ynout_nh)), int'($signed(mon_e)));
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [4*IN_W-1:0] pack_row(input int a, input int b, input int c, input int d);
        logic [4*IN_W-1:0] p;
        p[0*IN_W +: IN_W] = IN_W'(a);
        p[1*IN_W +: IN_W] = IN_W'(b);
        p[2*IN_W +: IN_W] = IN_W'(c);
        p[3*IN_W +: IN_W] = IN_W'(d);
        return p;
    endfunction

    task automatic send_row(input logic [4*IN_W-1:0] row, input logic m, input int max_gap);
        int gap, cnt;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            @(negedge clk);
            enable = 1'b0;
            xxin   = {4'($urandom), $urandom};
            mode   = 1'($urandom);
        end
        @(negedge clk);
        enable = 1'b1;
        xxin   = row;
        mode   = m;
        cnt    = 0;
        while (!ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (!ready) check("row_accept_timeout", 0, 1);
        @(posedge clk);
        #1 enable = 1'b0;
    endtask

    task automatic send_block(input blk_t x, input bit m, input int max_gap,
                              input coef_t y, input coef_t ynh);
        for (int r = 0; r < 4; r++) begin
            // MODE only matters on row 0; randomise it elsewhere.
            send_row(pack_row(x[r][0], x[r][1], x[r][2], x[r][3]),
                     (r == 0) ? m : 1'($urandom), max_gap);
        end
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(OUT_W'(y[k]));
            exp_nh_q.push_back(OUT_W'(ynh[k]));
        end
    endtask

    function automatic int rnd_sample();
        case ($urandom_range(9, 0))
            0:       return -256;
            1:       return 255;
            default: return int'($urandom_range(511, 0)) - 256;
        endcase
    endfunction

    task automatic random_block(input int max_gap);
        blk_t  x;
        coef_t y, ynh;
        bit    m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                x[r][c] = rnd_sample();
        m = 1'($urandom);
        model(x, m, y);
        model(x, 1'b0, ynh);
        send_block(x, m, max_gap, y, ynh);
    endtask

    task automatic wait_drain();
        int cnt;
        cnt = 0;
        while ((exp_q.size() > 0 || exp_nh_q.size() > 0) && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        if (exp_q.size() > 0 || exp_nh_q.size() > 0)
            check("drain_timeout", exp_q.size() + exp_nh_q.size(), 0);
        exp_q.delete();
        exp_nh_q.delete();
        repeat (3) @(negedge clk);
    endtask

    // ---------------- directed vectors ----------------
    vec_t tv [8];

    task automatic fill_vec(input int i, input int a, input int b, input int c,
                            input int d, input bit m);
        for (int r = 0; r < 4; r++) begin
            tv[i].x[r][0] = a; tv[i].x[r][1] = b;
            tv[i].x[r][2] = c; tv[i].x[r][3] = d;
        end
        tv[i].mode = m;
        for (int k = 0; k < 16; k++) begin
            tv[i].y[k]    = 0;
            tv[i].y_nh[k] = 0;
        end
    endtask

    task automatic init_table();
        int a [4];
        a = '{1, 2, 1, 1};
        fill_vec(0, 0, 0, 0, 0, 1'b0);
        fill_vec(1, 1, 1, 1, 1, 1'b0);
        tv[1].y[0] = 16;    tv[1].y_nh[0] = 16;
        fill_vec(2, -256, -256, -256, -256, 1'b0);
        tv[2].y[0] = -4096; tv[2].y_nh[0] = -4096;
        fill_vec(3, 0, 1, 2, 3, 1'b0);
        tv[3].y[0:3]    = '{24, -28, 0, -4};
        tv[3].y_nh[0:3] = '{24, -28, 0, -4};
        fill_vec(4, 255, 255, 255, 255, 1'b1);
        tv[4].y[0] = 2040;  tv[4].y_nh[0] = 4080;
        fill_vec(5, -256, -256, -256, -256, 1'b1);
        tv[5].y[0] = -2048; tv[5].y_nh[0] = -4096;
        fill_vec(6, 0, 1, 2, 3, 1'b1);
        tv[6].y[0:3]    = '{12, -8, 0, -4};
        tv[6].y_nh[0:3] = '{24, -28, 0, -4};
        // Single -1 sample: every Hadamard output is -1/2, floored to -1.
        fill_vec(7, 0, 0, 0, 0, 1'b1);
        tv[7].x[0][0] = -1;
        for (int u = 0; u < 4; u++)
            for (int v = 0; v < 4; v++) begin
                tv[7].y[u*4+v]    = -1;
                tv[7].y_nh[u*4+v] = -(a[u] * a[v]);
            end
    endtask

    // ---------------- throughput observer state ----------------
    int  rows_acc, valid_total, run, max_run, rows_at_low, valid_at_rise, first_low_len;
    bit  low_seen, rise_seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        enable = 1'b0;
        xxin   = '0;
        mode   = 1'b0;
        init_table();

        // Reset values, observed before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("reset_ready", int'(ready), 1);
        check("reset_valid", int'(valid), 0);
        check("reset_ynout", int'($signed(ynout)), 0);
        check("reset_ready_nh", int'(ready_nh), 1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 8; i++)
            send_block(tv[i].x, tv[i].mode, i % 3, tv[i].y, tv[i].y_nh);
        wait_drain();

        // Three blocks with ENABLE held: READY profile and gap-free output.
        rows_acc = 0; valid_total = 0; run = 0; max_run = 0;
        rows_at_low = -1; valid_at_rise = -1; first_low_len = 0;
        low_seen = 1'b0; rise_seen = 1'b0;
        fork
            begin
                for (int b = 0; b < 3; b++) random_block(0);
            end
            begin
                repeat (75) begin
                    @(negedge clk);
                    #2;
                    if (valid) begin
                        valid_total++;
                        run++;
                        if (run > max_run) max_run = run;
                    end else run = 0;
                    if (!ready && !low_seen) begin
                        low_seen    = 1'b1;
                        rows_at_low = rows_acc;
                    end
                    if (low_seen && !rise_seen) begin
                        if (ready) begin
                            rise_seen     = 1'b1;
                            valid_at_rise = valid_total;
                        end else first_low_len++;
                    end
                    if (enable && ready) rows_acc++;
                end
            end
        join
        check("rows_before_ready_low", rows_at_low, 8);
        check("ready_low_cycles", first_low_len, 12);
        check("valid_at_ready_rise", valid_at_rise, 16);
        check("valid_longest_run", max_run, 48);
        check("valid_total", valid_total, 48);
        check("rows_accepted", rows_acc, 12);
        wait_drain();

        // Reset at k=5 with a partial block queued in the other bank.
        random_block(0);
        send_row(pack_row(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample()), 1'b1, 0);
        send_row(pack_row(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample()), 1'b0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        check("valid_before_reset", int'(valid), 1);
        rst = 1'b1;
        #1;
        check("midreset_valid", int'(valid), 0);
        check("midreset_ynout", int'($signed(ynout)), 0);
        check("midreset_ready", int'(ready), 1);
        check("midreset_valid_nh", int'(valid_nh), 0);
        exp_q.delete();
        exp_nh_q.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        random_block(3);
        random_block(3);
        wait_drain();

        // Random blocks with random gaps and modes.
        for (int n = 0; n < 20; n++) random_block(3);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
